rice_core_rf_write_scheduler: RTL

//  Schedules the single register-file write port between the execute result (EX) and load return (LD).

---
 rtl/rice_core_pkg.sv | 25 ++
 rtl/rice_core_rf_scoreboard.sv | 63 ++++++
 rtl/rice_core_rf_write_scheduler.sv | 88 ++++++++
 3 files changed

// File: rtl/rice_core_pkg.sv
// Shared types for the rice core register-file write path.
// EX and LSU use the request struct; the write scheduler uses the source enum.
package rice_core_pkg;

  localparam int RICE_NUM_REGS = 32;
  localparam int RICE_REG_W    = 5;
  localparam int RICE_XLEN     = 32;

  typedef enum logic {
    RICE_WB_SRC_EX = 1'b0,
    RICE_WB_SRC_LD = 1'b1
  } rice_core_wb_source;

  typedef struct packed {
    logic                  valid;
    logic [RICE_REG_W-1:0] rd;
    logic [RICE_XLEN-1:0]  value;
  } rice_core_wb_request;

  function automatic logic [RICE_NUM_REGS-1:0] rice_core_onehot(input logic [RICE_REG_W-1:0] idx);
    rice_core_onehot = '0;
    rice_core_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rice_core_rf_scoreboard.sv
// Busy-register scoreboard: tracks outstanding writes and gates issue on
// RAW/WAW hazards and on the number of outstanding destinations.
module rice_core_rf_scoreboard
  import rice_core_pkg::*;
#(
  parameter int MAX_PENDING = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_issue_valid,
  input  logic [RICE_REG_W-1:0]    i_issue_rd,
  input  logic [RICE_REG_W-1:0]    i_rs1,
  input  logic [RICE_REG_W-1:0]    i_rs2,
  input  logic                     i_wb_valid,
  input  logic [RICE_REG_W-1:0]    i_wb_rd,
  output logic                     o_issue_ready,
  output logic [RICE_NUM_REGS-1:0] o_busy
);

  localparam int CNT_W = $clog2(RICE_NUM_REGS) + 1;

  logic [RICE_NUM_REGS-1:0] busy_reg, busy_next;
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [RICE_NUM_REGS-1:0] set_vec, clr_vec;
  logic                     set_fire, clr_fire;

  // Readiness looks only at current flops: a writeback in this cycle is not bypassed.
  assign o_issue_ready = !busy_reg[i_issue_rd] && !busy_reg[i_rs1] && !busy_reg[i_rs2] &&
                         ((count_reg < CNT_W'(MAX_PENDING)) || (i_issue_rd == '0));

  assign set_fire = i_issue_valid && o_issue_ready && (i_issue_rd != '0);
  // Writes to a register that is not busy leave the scoreboard untouched.
  assign clr_fire = i_wb_valid && busy_reg[i_wb_rd];

  always_comb begin
    set_vec = set_fire ? rice_core_onehot(i_issue_rd) : '0;
    clr_vec = clr_fire ? rice_core_onehot(i_wb_rd) : '0;
    busy_next = (busy_reg & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
    count_next = count_reg;
    case ({set_fire, clr_fire})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_reg  <= '0;
      count_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      count_reg <= count_next;
    end
  end

  assign o_busy = busy_reg;

  a_wb_to_busy: assert property (@(posedge i_clk) disable iff (i_rst) i_wb_valid |-> busy_reg[i_wb_rd])
    else $error("protocol error: register write to a register with no outstanding write");

endmodule

// File: rtl/rice_core_rf_write_scheduler.sv
// Arbitrates the single register-file write port between EX results and load
// returns (2-way round robin), registers the winning write, and owns the scoreboard.
module rice_core_rf_write_scheduler
  import rice_core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ex_valid,
  output logic                     o_ex_ready,
  input  logic [RICE_REG_W-1:0]    i_ex_rd,
  input  logic [XLEN-1:0]          i_ex_value,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [RICE_REG_W-1:0]    i_ld_rd,
  input  logic [XLEN-1:0]          i_ld_value,
  input  logic                     i_issue_valid,
  input  logic [RICE_REG_W-1:0]    i_issue_rd,
  input  logic [RICE_REG_W-1:0]    i_rs1,
  input  logic [RICE_REG_W-1:0]    i_rs2,
  output logic                     o_issue_ready,
  output logic                     o_wb_valid,
  output logic [RICE_REG_W-1:0]    o_wb_rd,
  output logic [XLEN-1:0]          o_wb_value,
  output logic [RICE_NUM_REGS-1:0] o_busy
);

  rice_core_wb_source last_grant_reg, last_grant_next;
  logic               grant_ex, grant_ld;
  logic               wb_valid_reg;
  logic [RICE_REG_W-1:0] wb_rd_reg;
  logic [XLEN-1:0]    wb_value_reg;

  // Under contention the source that did not win last time is granted;
  // lone requests do not move the round-robin pointer.
  always_comb begin
    grant_ex = i_ex_valid && (!i_ld_valid || (last_grant_reg == RICE_WB_SRC_LD));
    grant_ld = i_ld_valid && !grant_ex;
    last_grant_next = last_grant_reg;
    if (i_ex_valid && i_ld_valid) begin
      last_grant_next = grant_ex ? RICE_WB_SRC_EX : RICE_WB_SRC_LD;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant_reg <= RICE_WB_SRC_LD;
      wb_valid_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_value_reg   <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      // x0 writes are accepted but never reach the register file.
      wb_valid_reg   <= (grant_ex && (i_ex_rd != '0)) || (grant_ld && (i_ld_rd != '0));
      if (grant_ex) begin
        wb_rd_reg    <= i_ex_rd;
        wb_value_reg <= i_ex_value;
      end else if (grant_ld) begin
        wb_rd_reg    <= i_ld_rd;
        wb_value_reg <= i_ld_value;
      end
    end
  end

  assign o_ex_ready = grant_ex;
  assign o_ld_ready = grant_ld;
  assign o_wb_valid = wb_valid_reg;
  assign o_wb_rd    = wb_rd_reg;
  assign o_wb_value = wb_value_reg;

  rice_core_rf_scoreboard #(
    .MAX_PENDING (MAX_PENDING)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_wb_valid    (wb_valid_reg),
    .i_wb_rd       (wb_rd_reg),
    .o_issue_ready (o_issue_ready),
    .o_busy        (o_busy)
  );

endmodule
